// File: rtl/count_dec_pkg.sv
// Shared types and default widths for the counter step decoder.
// Step classification and FSM state encodings live here so the classifier and top agree.
package count_dec_pkg;

    localparam int unsigned DefCntW = 4;
    localparam int unsigned DefPosW = 16;

    typedef enum logic [1:0] {
        StUnlocked,
        StTrack,
        StError
    } dec_state_t;

    typedef enum logic [1:0] {
        KindHold,
        KindUp,
        KindDown,
        KindJump
    } step_kind_t;

endpackage

// File: rtl/count_delta_classify.sv
// Classifies the modular difference between the held sample and the new one.
// Purely combinational; wrap marks a step that crosses the max/0 boundary.
module count_delta_classify
    import count_dec_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic [CNT_W-1:0] last,
    input  logic [CNT_W-1:0] count_in,
    output step_kind_t       kind,
    output logic             wrap
);

    logic [CNT_W-1:0] delta;

    always_comb begin
        delta = count_in - last;
        kind  = KindJump;
        wrap  = 1'b0;
        if (delta == '0) begin
            kind = KindHold;
        end else if (delta == CNT_W'(1)) begin
            kind = KindUp;
            wrap = (last == '1);
        end else if (delta == '1) begin
            kind = KindDown;
            wrap = (last == '0);
        end
    end

endmodule

// File: rtl/count_step_decoder.sv
// Reconstructs step events, direction and a saturating signed position from an
// observed up/down counter value; flags any change other than +/-1 as a jump.
module count_step_decoder
    import count_dec_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW,
    parameter int unsigned POS_W = DefPosW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count_in,
    input  logic             sample_en,
    input  logic             clr,
    output logic             step,
    output logic             dir,
    output logic             wrap,
    output logic [POS_W-1:0] pos,
    output logic             sat,
    output logic             locked,
    output logic             err
);

    localparam logic [POS_W-1:0] PosMax = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] PosMin = {1'b1, {(POS_W-1){1'b0}}};

    dec_state_t       state_q, state_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;

    step_kind_t kind;
    logic       cls_wrap;

    count_delta_classify #(
        .CNT_W (CNT_W)
    ) u_classify (
        .last     (last_q),
        .count_in (count_in),
        .kind     (kind),
        .wrap     (cls_wrap)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        dir_d   = dir_q;
        pos_d   = pos_q;
        sat_d   = sat_q;
        err_d   = err_q;
        // clr outranks a coincident sample, which is dropped.
        if (clr) begin
            state_d = StUnlocked;
            pos_d   = '0;
            sat_d   = 1'b0;
            err_d   = 1'b0;
        end else if (sample_en) begin
            unique case (state_q)
                StUnlocked: begin
                    last_d  = count_in;
                    state_d = StTrack;
                end
                StTrack: begin
                    last_d = count_in;
                    unique case (kind)
                        KindUp: begin
                            step_d = 1'b1;
                            dir_d  = 1'b1;
                            wrap_d = cls_wrap;
                            if (pos_q == PosMax) sat_d = 1'b1;
                            else                 pos_d = pos_q + POS_W'(1);
                        end
                        KindDown: begin
                            step_d = 1'b1;
                            dir_d  = 1'b0;
                            wrap_d = cls_wrap;
                            if (pos_q == PosMin) sat_d = 1'b1;
                            else                 pos_d = pos_q - POS_W'(1);
                        end
                        KindJump: begin
                            err_d   = 1'b1;
                            state_d = StError;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StUnlocked;
            last_q  <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b1;
            wrap_q  <= 1'b0;
            pos_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            pos_q   <= pos_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    assign step   = step_q;
    assign dir    = dir_q;
    assign wrap   = wrap_q;
    assign pos    = pos_q;
    assign sat    = sat_q;
    assign err    = err_q;
    assign locked = (state_q == StTrack);

endmodule

// File: tb/tb_count_step_decoder.sv
// Bench for count_step_decoder: directed vector table, hand sequences for saturation and
// asynchronous reset, then random walks against an integer reference model.
module tb_count_step_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count_in = '0;
    logic       sample_en = 1'b0;
    logic       clr = 1'b0;

    logic        step, dir, wrap, sat, locked, err;
    logic [15:0] pos;
    logic        s_step, s_dir, s_wrap, s_sat, s_locked, s_err;
    logic [3:0]  s_pos;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    count_step_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .sample_en (sample_en),
        .clr       (clr),
        .step      (step),
        .dir       (dir),
        .wrap      (wrap),
        .pos       (pos),
        .sat       (sat),
        .locked    (locked),
        .err       (err)
    );

    count_step_decoder #(
        .CNT_W (4),
        .POS_W (4)
    ) dut_s (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .sample_en (sample_en),
        .clr       (clr),
        .step      (s_step),
        .dir       (s_dir),
        .wrap      (s_wrap),
        .pos       (s_pos),
        .sat       (s_sat),
        .locked    (s_locked),
        .err       (s_err)
    );

    // Reference model: integer position, modular delta, explicit clamp limits.
    int m_last, m_pos, m_pos4;
    bit m_locked, m_err, m_dir, m_step, m_wrap, m_sat, m_sat4;

    task automatic model_reset();
        m_last = 0; m_pos = 0; m_pos4 = 0;
        m_locked = 0; m_err = 0; m_dir = 1; m_step = 0; m_wrap = 0; m_sat = 0; m_sat4 = 0;
    endtask

    task automatic acc(inout int p, inout bit s, input int d, input int hi, input int lo);
        int n;
        n = p + d;
        if (n > hi || n < lo) s = 1;
        else p = n;
    endtask

    task automatic model_clock(input bit se, input bit cl, input int c);
        int d;
        m_step = 0;
        m_wrap = 0;
        if (cl) begin
            m_pos = 0; m_pos4 = 0; m_sat = 0; m_sat4 = 0; m_err = 0; m_locked = 0;
        end else if (se && !m_err) begin
            if (!m_locked) begin
                m_locked = 1;
            end else begin
                d = (c - m_last + 16) % 16;
                if (d == 1 || d == 15) begin
                    m_step = 1;
                    m_dir  = (d == 1);
                    m_wrap = (d == 1) ? (m_last == 15) : (m_last == 0);
                    acc(m_pos, m_sat, (d == 1) ? 1 : -1, 32767, -32768);
                    acc(m_pos4, m_sat4, (d == 1) ? 1 : -1, 7, -8);
                end else if (d != 0) begin
                    m_err = 1;
                    m_locked = 0;
                end
            end
            m_last = c;
        end
    endtask

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " step"},     int'(step),          int'(m_step));
        check({tag, " dir"},      int'(dir),           int'(m_dir));
        check({tag, " wrap"},     int'(wrap),          int'(m_wrap));
        check({tag, " pos"},      int'($signed(pos)),  m_pos);
        check({tag, " sat"},      int'(sat),           int'(m_sat));
        check({tag, " locked"},   int'(locked),        int'(m_locked));
        check({tag, " err"},      int'(err),           int'(m_err));
        check({tag, " s_step"},   int'(s_step),        int'(m_step));
        check({tag, " s_pos"},    int'($signed(s_pos)), m_pos4);
        check({tag, " s_sat"},    int'(s_sat),         int'(m_sat4));
        check({tag, " s_locked"}, int'(s_locked),      int'(m_locked));
        check({tag, " s_err"},    int'(s_err),         int'(m_err));
    endtask

    // One clock: drive, advance, update the model, then sample 1 time unit after the edge.
    task automatic cycle(input logic se, input logic cl, input logic [3:0] c);
        sample_en = se;
        clr       = cl;
        count_in  = c;
        @(posedge clk);
        model_clock(se, cl, int'(c));
        #1;
    endtask

    typedef struct {
        logic       se;
        logic       cl;
        logic [3:0] cnt;
        logic       st;
        logic       dr;
        logic       wr;
        int         p;
        logic       lk;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic se, input logic cl, input logic [3:0] c, input logic st,
                       input logic dr, input logic wr, input int p, input logic lk,
                       input logic er);
        vec_t v;
        v = '{se, cl, c, st, dr, wr, p, lk, er};
        vecs.push_back(v);
    endtask

    initial begin
        //   se    cl    cnt    step  dir   wrap  pos lock  err
        add(1'b1, 1'b0, 4'd3,  1'b0, 1'b1, 1'b0,  0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd4,  1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd5,  1'b1, 1'b1, 1'b0,  2, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd6,  1'b1, 1'b1, 1'b0,  3, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'd9,  1'b0, 1'b1, 1'b0,  3, 1'b1, 1'b0);
        add(1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0,  0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 4'd1,  1'b0, 1'b1, 1'b0,  0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, -2, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0, -3, 1'b1, 1'b0);
        add(1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0,  0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0,  0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0,  0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd9,  1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 4'd8,  1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 4'd9,  1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 4'd9,  1'b0, 1'b0, 1'b0,  0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd10, 1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b0);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset step",   int'(step),   0);
        check("reset dir",    int'(dir),    1);
        check("reset wrap",   int'(wrap),   0);
        check("reset pos",    int'(pos),    0);
        check("reset sat",    int'(sat),    0);
        check("reset locked", int'(locked), 0);
        check("reset err",    int'(err),    0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].se, vecs[i].cl, vecs[i].cnt);
            check($sformatf("vec%0d step", i),   int'(step),         int'(vecs[i].st));
            check($sformatf("vec%0d dir", i),    int'(dir),          int'(vecs[i].dr));
            check($sformatf("vec%0d wrap", i),   int'(wrap),         int'(vecs[i].wr));
            check($sformatf("vec%0d pos", i),    int'($signed(pos)), vecs[i].p);
            check($sformatf("vec%0d sat", i),    int'(sat),          0);
            check($sformatf("vec%0d locked", i), int'(locked),       int'(vecs[i].lk));
            check($sformatf("vec%0d err", i),    int'(err),          int'(vecs[i].er));
        end

        // Saturation on the 4-bit position instance.
        cycle(1'b0, 1'b1, 4'd0);
        cycle(1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 1'b0, 4'(k));
            check($sformatf("sat up%0d s_pos", k),  int'($signed(s_pos)), (k < 7) ? k : 7);
            check($sformatf("sat up%0d s_sat", k),  int'(s_sat),  (k == 8) ? 1 : 0);
            check($sformatf("sat up%0d s_step", k), int'(s_step), 1);
            check_model($sformatf("sat up%0d", k));
        end
        cycle(1'b1, 1'b0, 4'd7);
        check("sat down s_pos", int'($signed(s_pos)), 6);
        check("sat down s_sat", int'(s_sat), 1);
        check("sat down pos",   int'($signed(pos)), 7);

        // Asynchronous reset while tracking with pos=5.
        cycle(1'b0, 1'b1, 4'd0);
        cycle(1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 5; k++) cycle(1'b1, 1'b0, 4'(k));
        check("pre-rst pos", int'($signed(pos)), 5);
        sample_en = 1'b1;
        count_in  = 4'd6;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async rst pos",    int'(pos),    0);
        check("async rst locked", int'(locked), 0);
        check("async rst dir",    int'(dir),    1);
        check_model("async rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, 1'b0, 4'd3);
        check("post-rst lock step", int'(step), 0);
        check("post-rst lock pos",  int'(pos),  0);
        check_model("post-rst lock");
        cycle(1'b1, 1'b0, 4'd4);
        check("post-rst step pos", int'($signed(pos)), 1);
        check_model("post-rst step");

        // Random walks with occasional holds, jumps and clears.
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [3:0] c;
            r = int'($urandom_range(0, 15));
            if (r < 7)       c = 4'(m_last + 1);
            else if (r < 12) c = 4'(m_last - 1);
            else if (r < 14) c = 4'(m_last);
            else             c = 4'($urandom);
            cycle(($urandom % 4) != 0, ($urandom % 25) == 0, c);
            check_model($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_step_decoder.md
# count_step_decoder

Receive-side companion to the 4-bit up/down counter: samples the counter's `count` output and reconstructs step events, count direction and an extended signed position. It flags illegal jumps, meaning any change other than ±1 modulo 2^CNT_W. It sits on the observation path next to the counter and feeds status/debug logic and the simulation scoreboard.

## Interface
- `CNT_W`, 4: width of observed count.
- `POS_W`, 16: width of signed extended position accumulator.
- `clk  in  1`: single clock, all logic rising-edge.
- `rst  in  1`: asynchronous, active-high reset.
- `count_in  in  CNT_W`: observed counter value.
- `sample_en  in  1`: qualifies `count_in` this cycle.
- `clr  in  1`: synchronous clear of error/lock state and position.
- `step  out  1`: one-cycle pulse, a ±1 step was decoded.
- `dir  out  1`: direction of last decoded step (1 up, 0 down).
- `wrap  out  1`: one-cycle pulse, step crossed max→0 (up) or 0→max (down).
- `pos  out  POS_W`: signed accumulated position.
- `sat  out  1`: sticky, `pos` hit a signed limit.
- `locked  out  1`: a reference sample is held and tracking is active.
- `err  out  1`: sticky, illegal jump detected.

## Operation
- Reset values: `step`=0, `dir`=1, `wrap`=0, `pos`=0, `sat`=0, `locked`=0, `err`=0, `last`=0, state=UNLOCKED.
- States:
  - UNLOCKED: on `sample_en`, capture `last`←`count_in`, go to TRACK, `locked`←1. No step is emitted.
  - TRACK: on `sample_en`, compute `delta` = (`count_in` − `last`) mod 2^CNT_W, then `last`←`count_in`.
    - `delta`=0: hold, no outputs change.
    - `delta`=1: `step`, `dir`←1, `pos`+1. `wrap` if `last`=2^CNT_W−1.
    - `delta`=2^CNT_W−1: `step`, `dir`←0, `pos`−1. `wrap` if `last`=0.
    - Any other `delta`: `err`←1, `locked`←0, go to ERROR. `pos` is unchanged.
  - ERROR: `sample_en` is ignored and `pos` is frozen. `clr` returns to UNLOCKED.
- `clr` in any state: `pos`←0, `sat`←0, `err`←0, `locked`←0, state←UNLOCKED. `dir` keeps its value.
- Arithmetic:
  - `delta` uses CNT_W-bit unsigned subtraction.
  - `pos` saturates at +2^(POS_W−1)−1 and −2^(POS_W−1). A step that would overflow leaves `pos` at the limit, sets `sat`, and still pulses `step`.
- Without `sample_en`: `step`/`wrap` are 0 and nothing else changes.

## Timing
- All outputs are registered.
- `step`, `wrap`, `dir` and `pos` update at the clock edge that samples `sample_en`=1, so they are visible the following cycle. Latency is 1 cycle.
- `step` and `wrap` are single-cycle pulses. Back-to-back `sample_en` produces back-to-back pulses with no bubble.
- `clr` and `sample_en` in the same cycle: `clr` wins and the sample is discarded (state becomes UNLOCKED, not TRACK).
- A jump and a saturation cannot coincide, because a jump never changes `pos`.
- `rst` mid-operation forces the reset values immediately and asynchronously. The first `sample_en` after release re-locks only.

## Structure
- Package `count_dec_pkg` holds:
  - state enum `dec_state_t` {UNLOCKED, TRACK, ERROR};
  - step classification enum `step_kind_t` {HOLD, UP, DOWN, JUMP};
  - default parameter constants.
- Sub-module `count_delta_classify`: combinational; takes `last` and `count_in`, returns `step_kind_t` and a wrap flag.
- Top level: FSM, `last` register, saturating position accumulator, output registers.

## Test plan
- Reset, then `sample_en` with `count_in` 3,4,5,6 → lock on 3; three `step` pulses; `dir`=1; `pos`=3; `wrap`=0.
- Lock at 1, then 0,15,14 → three steps with `dir`=0; `pos`=−3; `wrap` pulses only on the 0→15 step.
- Lock at 7, then repeated 7 with `sample_en`, then 7→9 → no `step` on the repeats; on the jump `err`=1 and `locked`=0; `pos` stays 0; further samples are ignored.
- In ERROR, assert `clr` and `sample_en` together with `count_in`=9 → UNLOCKED with `err`=0, `pos`=0; next sample 9 locks; 10 gives `pos`=1.
- POS_W=4 override, 8 up steps → `pos` holds at 7 and `sat`=1 on the 8th step; that step still pulses `step`.
- Assert `rst` mid-TRACK with `pos`=5 → all outputs return to reset values the same cycle; after release, the first sample only locks.
